// File: rtl/sram_test_pkg.sv
// Shared types and constants for the LSRAM fill/check blocks.
package sram_test_pkg;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned ADDR_W = 10;

  localparam logic [DATA_W-1:0] INIT_VAL_DEFAULT  = 20'h74D0D;
  localparam logic [DATA_W-1:0] INC_VAL_DEFAULT   = 20'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR_DEFAULT = 10'd1023;

  // Read-back settle cycles spent in VSETUP beyond its entry cycle.
  localparam logic [1:0] VSETUP_WAIT = 2'd3;

  typedef enum logic [2:0] {IDLE, WRITE, VSETUP, VCHECK, DONE} state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/sram_fill_module.sv
// Fills LSRAM port A with an arithmetic pattern and reports done/irq.
// Define SRAM_FILL_VERIFY_EN to add a read-back pass that sets error_latch on mismatch.
module sram_fill_module
  import sram_test_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL_ADDR0 = INIT_VAL_DEFAULT,
  parameter logic [DATA_W-1:0] INC_VAL        = INC_VAL_DEFAULT,
  parameter logic [ADDR_W-1:0] LAST_ADDR      = LAST_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_fill,
  input  logic              abort,
  input  logic              clr_status,
  input  logic [DATA_W-1:0] data_read_portA,
  output logic              wen_portA,
  output logic [ADDR_W-1:0] addr_portA,
  output logic [DATA_W-1:0] data_write_portA,
  output logic              busy,
  output logic              error_latch,
  output logic              done_latch,
  output logic              done_irq
);

  state_e            r_state;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_pattern;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_irq;
  logic              w_start;
  logic [DATA_W-1:0] w_next_pattern;

`ifdef SRAM_FILL_VERIFY_EN
  logic       r_error;
  logic [1:0] r_wait;
`else
  logic       w_unused_rd;
  assign w_unused_rd = ^data_read_portA;
`endif

  pulse_sync_edge u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (start_fill),
    .o_pulse (w_start)
  );

  assign w_next_pattern = r_pattern + INC_VAL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_pattern <= INIT_VAL_ADDR0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
`ifdef SRAM_FILL_VERIFY_EN
      r_error   <= 1'b0;
      r_wait    <= '0;
`endif
    end else begin
      // Status clear comes first so any set later in this block wins.
      if (clr_status) begin
        r_done  <= 1'b0;
        r_irq   <= 1'b0;
`ifdef SRAM_FILL_VERIFY_EN
        r_error <= 1'b0;
`endif
      end
      if (abort) begin
        r_state   <= IDLE;
        r_wen     <= 1'b0;
        r_addr    <= '0;
        r_pattern <= INIT_VAL_ADDR0;
        r_wdata   <= '0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_pattern <= INIT_VAL_ADDR0;
            r_wdata   <= '0;
            if (w_start) begin
              r_state <= WRITE;
              r_busy  <= 1'b1;
              r_wen   <= 1'b1;
              r_wdata <= INIT_VAL_ADDR0;
              r_done  <= 1'b0;
              r_irq   <= 1'b0;
`ifdef SRAM_FILL_VERIFY_EN
              r_error <= 1'b0;
`endif
            end
          end
          WRITE: begin
            if (r_addr == LAST_ADDR) begin
              r_wen   <= 1'b0;
              r_wdata <= '0;
`ifdef SRAM_FILL_VERIFY_EN
              r_state   <= VSETUP;
              r_addr    <= '0;
              r_pattern <= INIT_VAL_ADDR0;
              r_wait    <= '0;
`else
              r_state <= DONE;
`endif
            end else begin
              r_addr    <= r_addr + 1'b1;
              r_pattern <= w_next_pattern;
              r_wdata   <= w_next_pattern;
            end
          end
`ifdef SRAM_FILL_VERIFY_EN
          VSETUP: begin
            if (r_wait == VSETUP_WAIT) begin
              r_state <= VCHECK;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          VCHECK: begin
            if (data_read_portA != r_pattern) begin
              r_error <= 1'b1;
            end
            if (r_addr == LAST_ADDR) begin
              r_state <= DONE;
            end else begin
              r_state   <= VSETUP;
              r_addr    <= r_addr + 1'b1;
              r_pattern <= w_next_pattern;
              r_wait    <= '0;
            end
          end
`endif
          DONE: begin
            r_done    <= 1'b1;
            r_irq     <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_pattern <= INIT_VAL_ADDR0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign wen_portA        = r_wen;
  assign addr_portA       = r_addr;
  assign data_write_portA = r_wdata;
  assign busy             = r_busy;
  assign done_latch       = r_done;
  assign done_irq         = r_irq;
`ifdef SRAM_FILL_VERIFY_EN
  assign error_latch      = r_error;
`else
  assign error_latch      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fill_module.sv
// Scoreboard bench: stimulus queues the expected writes, a monitor pops them as the DUTs write.
module tb_sram_fill_module;
  import sram_test_pkg::*;

  localparam logic [19:0] Init1 = 20'h74D0D;
  localparam logic [19:0] Inc1  = 20'd2;
  localparam logic [19:0] Init2 = 20'hFFFFF;
  localparam logic [19:0] Inc2  = 20'd1;
  localparam int Words = 1024;
`ifdef SRAM_FILL_VERIFY_EN
  localparam int DoneGap = 1 + 5 * Words;
`else
  localparam int DoneGap = 1;
`endif
  localparam int RunBound = Words * 6 + 100;

  typedef struct packed {
    logic [9:0]  a;
    logic [19:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n, start_fill, abort, clr_status;
  logic no_abort = 1'b0;
  logic no_clr = 1'b0;
  logic        wen1, wen2, busy1, busy2, err1, err2, done1, done2, irq1, irq2;
  logic [9:0]  addr1, addr2;
  logic [19:0] wd1, wd2, rd1, rd2;
  logic [19:0] mem1 [Words];
  logic [19:0] mem2 [Words];
  bit          corrupt7 = 1'b0;

  wr_t q1[$];
  wr_t q2[$];
  wr_t e1, e2;
  int  n_checks = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  sram_fill_module u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_fill(start_fill), .abort(abort),
    .clr_status(clr_status), .data_read_portA(rd1), .wen_portA(wen1), .addr_portA(addr1),
    .data_write_portA(wd1), .busy(busy1), .error_latch(err1), .done_latch(done1),
    .done_irq(irq1)
  );

  sram_fill_module #(.INIT_VAL_ADDR0(Init2), .INC_VAL(Inc2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_fill(start_fill), .abort(no_abort),
    .clr_status(no_clr), .data_read_portA(rd2), .wen_portA(wen2), .addr_portA(addr2),
    .data_write_portA(wd2), .busy(busy2), .error_latch(err2), .done_latch(done2),
    .done_irq(irq2)
  );

  // Registered-read SRAM models; corrupt7 flips bit0 of address 7 on read.
  always @(posedge clk) begin
    if (wen1) mem1[addr1] <= wd1;
    if (wen2) mem2[addr2] <= wd2;
    rd1 <= mem1[addr1] ^ ((corrupt7 && addr1 == 10'd7) ? 20'h1 : 20'h0);
    rd2 <= mem2[addr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // data(n) = INIT + n*INC modulo 2^20, for the first n1/n2 words of a run.
  task automatic plan_run(input int n1, input int n2);
    logic [31:0] v;
    for (int n = 0; n < n1; n++) begin
      v = 32'(Init1) + n * 32'(Inc1);
      q1.push_back({10'(n), v[19:0]});
    end
    for (int n = 0; n < n2; n++) begin
      v = 32'(Init2) + n * 32'(Inc2);
      q2.push_back({10'(n), v[19:0]});
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_write(input int a, input int bound);
    int i = 0;
    while (!(wen1 === 1'b1 && addr1 == 10'(a)) && i < bound) begin
      tick();
      i++;
    end
    if (i >= bound) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_write: no write at addr %0d within %0d cycles", a, bound);
    end
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while ((busy1 !== 1'b0 || busy2 !== 1'b0) && i < bound) begin
      tick();
      i++;
    end
    if (i >= bound) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
  endtask

  task automatic new_start(input int n1, input int n2);
    start_fill = 1'b0;
    repeat ($urandom_range(3, 8)) tick();
    plan_run(n1, n2);
    start_fill = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (wen1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected write: addr %0h data %0h, expected none", addr1, wd1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 addr", 32'(addr1), 32'(e1.a));
        check("dut1 data", 32'(wd1), 32'(e1.d));
      end
    end else begin
      check("dut1 idle data", 32'(wd1), 32'h0);
    end
    if (wen2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 unexpected write: addr %0h data %0h, expected none", addr2, wd2);
      end else begin
        e2 = q2.pop_front();
        check("dut2 addr", 32'(addr2), 32'(e2.a));
        check("dut2 data", 32'(wd2), 32'(e2.d));
      end
    end else begin
      check("dut2 idle data", 32'(wd2), 32'h0);
    end
  end

  initial begin
    int cnt;
    int at;
    rst_n = 1'b0; start_fill = 1'b0; abort = 1'b0; clr_status = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset wen", 32'(wen1), 0);
    check("reset addr", 32'(addr1), 0);
    check("reset busy", 32'(busy1), 0);
    check("reset done", 32'(done1), 0);
    check("reset irq", 32'(irq1), 0);
    check("reset err", 32'(err1), 0);
    check("reset dut2 busy", 32'(busy2), 0);

    // Full fill: 3-cycle latency, 1024 contiguous writes, done/irq set.
    plan_run(Words, Words);
    start_fill = 1'b1;
    tick(); check("latency c1 wen", 32'(wen1), 0);
    tick(); check("latency c2 wen", 32'(wen1), 0);
    tick(); check("latency c3 wen", 32'(wen1), 1);
    check("busy at first write", 32'(busy1), 1);
    cnt = 0;
    while (wen1 === 1'b1 && cnt < 2000) begin
      cnt++;
      tick();
    end
    check("run1 write count", cnt, Words);
    wait_idle(RunBound);
    check("run1 done", 32'(done1), 1);
    check("run1 irq", 32'(irq1), 1);
    check("run1 err", 32'(err1), 0);
    check("dut2 run1 done", 32'(done2), 1);
    check("dut2 run1 err", 32'(err2), 0);

    // Abort at address 100; the start clears the previous done.
    new_start(101, Words);
    wait_write(100, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort wen", 32'(wen1), 0);
    check("abort busy", 32'(busy1), 0);
    check("abort done", 32'(done1), 0);
    check("abort addr", 32'(addr1), 0);
    wait_idle(RunBound);
    check("abort q1 drained", q1.size(), 0);
    check("abort dut2 done", 32'(done2), 1);

    // Random abort points.
    for (int k = 0; k < 3; k++) begin
      at = $urandom_range(1, 1022);
      new_start(at + 1, Words);
      wait_write(at, 1200);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("rand abort wen", 32'(wen1), 0);
      check("rand abort done", 32'(done1), 0);
      wait_idle(RunBound);
      check("rand abort q1 drained", q1.size(), 0);
    end

    // Retrigger mid-run is ignored; clr_status during DONE loses to the set.
    new_start(Words, Words);
    wait_write(500, 600);
    start_fill = 1'b0;
    repeat (3) tick();
    start_fill = 1'b1;
    repeat (3) tick();
    wait_write(1023, 700);
    repeat (DoneGap) tick();
    check("done cycle busy", 32'(busy1), 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr vs set done", 32'(done1), 1);
    check("clr vs set irq", 32'(irq1), 1);
    check("after done busy", 32'(busy1), 0);
    repeat (30) tick();
    check("no second run q1", q1.size(), 0);
    check("no second run q2", q2.size(), 0);
    check("no second run wen", 32'(wen1), 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr done", 32'(done1), 0);
    check("clr irq", 32'(irq1), 0);
    check("dut2 unaffected done", 32'(done2), 1);

`ifdef SRAM_FILL_VERIFY_EN
    // Read-back mismatch at address 7, then a fresh start clears the flags.
    corrupt7 = 1'b1;
    new_start(Words, Words);
    repeat (4) tick();
    wait_idle(RunBound);
    check("verify err set", 32'(err1), 1);
    check("verify done set", 32'(done1), 1);
    check("verify dut2 err", 32'(err2), 0);
    corrupt7 = 1'b0;
    new_start(Words, Words);
    repeat (4) tick();
    check("restart clears err", 32'(err1), 0);
    check("restart clears done", 32'(done1), 0);
    wait_idle(RunBound);
    check("clean verify err", 32'(err1), 0);
    check("clean verify done", 32'(done1), 1);
`endif

    // Reset in the middle of a run.
    at = $urandom_range(10, 900);
    new_start(at + 1, at + 1);
    wait_write(at, 1200);
    rst_n = 1'b0;
    tick();
    check("midrun reset wen", 32'(wen1), 0);
    check("midrun reset addr", 32'(addr1), 0);
    check("midrun reset busy", 32'(busy1), 0);
    check("midrun reset dut2 wen", 32'(wen2), 0);
    rst_n = 1'b1;
    start_fill = 1'b0;
    repeat (10) tick();
    check("midrun q1 drained", q1.size(), 0);
    check("midrun q2 drained", q2.size(), 0);
    check("midrun no restart", 32'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
